// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative RISC-V M-extension multiply/divide unit.
//
// Radix-2 datapath: one shift-add (multiply) or restoring shift-subtract (divide) step per
// cycle on operand magnitudes, followed by a single sign-fix cycle. Divide-by-zero and
// signed overflow bypass the iteration and complete one cycle after accept.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   request valid
//   in_ready   unit idle, request accepted when in_valid && in_ready && !kill
//   func3      M-extension op (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   word       RV64 W-form select (ignored when XLEN == 32)
//   rs1, rs2   operands (rs1 = multiplicand / dividend)
//   kill       synchronous abort of the in-flight operation
//   out_valid  result valid
//   out_ready  consumer accepts result
//   rd         result, held stable while out_valid && !out_ready

module muldiv_iter #(
   parameter int unsigned XLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      func3,
   input  logic            word,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   input  logic            kill,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] rd
);

   localparam int unsigned IW = $clog2(XLEN);
   localparam int unsigned CW = IW + 1;

   typedef enum logic [1:0] {
      StIdle,
      StCalc,
      StFix,
      StDone
   } state_e;

   state_e              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [XLEN-1:0]     a_q, a_d;       // multiplicand / dividend magnitude
   logic [XLEN-1:0]     b_q, b_d;       // multiplier / divisor magnitude
   logic [XLEN-1:0]     rem_q, rem_d;   // partial remainder
   logic [2*XLEN-1:0]   acc_q, acc_d;   // product, or quotient in the low half
   logic [XLEN-1:0]     rd_q, rd_d;
   logic [2:0]          op_q, op_d;
   logic                word_q, word_d;
   logic                neg_q, neg_d;   // negate product / quotient
   logic                rneg_q, rneg_d; // negate remainder

   function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
      return XLEN'($signed(v));
   endfunction

   // ---------------------------------------------------------------------------------------
   // Request decode (only meaningful in StIdle)
   // ---------------------------------------------------------------------------------------
   logic            word_eff;
   logic            is_div;
   logic            sg1, sg2;
   logic [XLEN-1:0] ext1, ext2;
   logic            neg1, neg2;
   logic [XLEN-1:0] mag1, mag2;
   logic [XLEN-1:0] min_val;
   logic            div_zero, div_ovf, special;
   logic [XLEN-1:0] sp_raw, sp_res;
   logic            accept;

   always_comb begin
      word_eff = (XLEN == 64) ? word : 1'b0;
      is_div   = func3[2];
      // MULHW/MULHSUW/MULHUW do not exist; in word mode they collapse onto MULW, whose low
      // half is sign-agnostic, so both operands are treated as unsigned.
      if (is_div) begin
         sg1 = ~func3[0];
         sg2 = ~func3[0];
      end else begin
         sg1 = ~word_eff && ((func3[1:0] == 2'b01) || (func3[1:0] == 2'b10));
         sg2 = ~word_eff && (func3[1:0] == 2'b01);
      end

      if (word_eff) begin
         ext1 = sg1 ? sext32(rs1[31:0]) : XLEN'(rs1[31:0]);
         ext2 = sg2 ? sext32(rs2[31:0]) : XLEN'(rs2[31:0]);
      end else begin
         ext1 = rs1;
         ext2 = rs2;
      end

      neg1 = sg1 & ext1[XLEN-1];
      neg2 = sg2 & ext2[XLEN-1];
      mag1 = neg1 ? -ext1 : ext1;
      mag2 = neg2 ? -ext2 : ext2;

      min_val  = word_eff ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
      div_zero = is_div && (ext2 == '0);
      div_ovf  = is_div && sg1 && (ext1 == min_val) && (&ext2);
      special  = div_zero || div_ovf;

      // func3[1] distinguishes REM* from DIV*
      if (div_zero) sp_raw = func3[1] ? ext1 : '1;
      else          sp_raw = func3[1] ? '0 : ext1;
      sp_res = word_eff ? sext32(sp_raw[31:0]) : sp_raw;

      accept = in_valid && (state_q == StIdle) && !kill;
   end

   // ---------------------------------------------------------------------------------------
   // Iteration step
   // ---------------------------------------------------------------------------------------
   logic [IW-1:0]     bit_idx;
   logic [2*XLEN-1:0] prod_step;
   logic [XLEN:0]     r_try, r_sub;
   logic              q_bit;

   always_comb begin
      // Operand bits are consumed MSB-first; the counter doubles as the bit index.
      bit_idx   = IW'(cnt_q - CW'(1));
      prod_step = {acc_q[2*XLEN-2:0], 1'b0} +
                  (b_q[bit_idx] ? {{XLEN{1'b0}}, a_q} : {(2*XLEN){1'b0}});
      r_try     = {rem_q, a_q[bit_idx]};
      r_sub     = r_try - {1'b0, b_q};
      // r_try < 2*divisor, so the subtraction borrows exactly when r_try < divisor
      q_bit     = ~r_sub[XLEN];
   end

   // ---------------------------------------------------------------------------------------
   // Sign fix and result select
   // ---------------------------------------------------------------------------------------
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quo_fix, rem_fix, sel_res, fix_res;

   always_comb begin
      prod_fix = neg_q ? -acc_q : acc_q;
      quo_fix  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
      rem_fix  = rneg_q ? -rem_q : rem_q;
      if (op_q[2]) begin
         sel_res = op_q[1] ? rem_fix : quo_fix;
      end else if (word_q || (op_q[1:0] == 2'b00)) begin
         sel_res = prod_fix[XLEN-1:0];
      end else begin
         sel_res = prod_fix[2*XLEN-1:XLEN];
      end
      fix_res = word_q ? sext32(sel_res[31:0]) : sel_res;
   end

   // ---------------------------------------------------------------------------------------
   // Control FSM next state
   // ---------------------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      rem_d   = rem_q;
      acc_d   = acc_q;
      rd_d    = rd_q;
      op_d    = op_q;
      word_d  = word_q;
      neg_d   = neg_q;
      rneg_d  = rneg_q;

      case (state_q)
         StIdle: begin
            if (accept) begin
               op_d   = func3;
               word_d = word_eff;
               neg_d  = neg1 ^ neg2;
               rneg_d = neg1;
               a_d    = mag1;
               b_d    = mag2;
               acc_d  = '0;
               rem_d  = '0;
               if (special) begin
                  rd_d    = sp_res;
                  cnt_d   = '0;
                  state_d = StDone;
               end else begin
                  cnt_d   = word_eff ? CW'(32) : CW'(XLEN);
                  state_d = StCalc;
               end
            end
         end
         StCalc: begin
            if (kill) begin
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q - CW'(1);
               if (op_q[2]) begin
                  rem_d = q_bit ? r_sub[XLEN-1:0] : r_try[XLEN-1:0];
                  acc_d = {acc_q[2*XLEN-2:0], q_bit};
               end else begin
                  acc_d = prod_step;
               end
               if (cnt_q == CW'(1)) state_d = StFix;
            end
         end
         StFix: begin
            if (kill) begin
               state_d = StIdle;
            end else begin
               rd_d    = fix_res;
               state_d = StDone;
            end
         end
         StDone: begin
            // kill wins over a simultaneous out_ready
            if (kill || out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         rem_q   <= '0;
         acc_q   <= '0;
         rd_q    <= '0;
         op_q    <= '0;
         word_q  <= 1'b0;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         rem_q   <= rem_d;
         acc_q   <= acc_d;
         rd_q    <= rd_d;
         op_q    <= op_d;
         word_q  <= word_d;
         neg_q   <= neg_d;
         rneg_q  <= rneg_d;
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign rd        = rd_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Self-checking bench for muldiv_iter (XLEN = 64): directed cases, flow control, kill,
// mid-operation reset and randomized operations against an arithmetic reference model.

module tb_muldiv_iter;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  func3;
   logic        word;
   logic [63:0] rs1, rs2;
   logic        kill;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] rd;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   muldiv_iter #(.XLEN(64)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .func3     (func3),
      .word      (word),
      .rs1       (rs1),
      .rs2       (rs2),
      .kill      (kill),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .rd        (rd)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] sx32(input logic [31:0] v);
      return {{32{v[31]}}, v};
   endfunction

   // Reference: RISC-V M semantics computed with plain wide arithmetic.
   function automatic logic [63:0] ref_model(input logic [2:0] f, input logic w,
                                             input logic [63:0] a, input logic [63:0] b);
      logic [127:0] p;
      longint       sa, sb;
      int           s1, s2;
      logic [31:0]  q32, r32;
      logic [63:0]  q, r;
      if (!f[2]) begin
         if (w) begin
            p = {96'b0, a[31:0]} * {96'b0, b[31:0]};
            return sx32(p[31:0]);
         end
         case (f[1:0])
            2'b00:   p = {64'b0, a} * {64'b0, b};
            2'b01:   p = {{64{a[63]}}, a} * {{64{b[63]}}, b};
            2'b10:   p = {{64{a[63]}}, a} * {64'b0, b};
            default: p = {64'b0, a} * {64'b0, b};
         endcase
         return (f[1:0] == 2'b00) ? p[63:0] : p[127:64];
      end
      if (w) begin
         s1 = a[31:0];
         s2 = b[31:0];
         if (b[31:0] == 32'h0) begin
            q32 = 32'hFFFF_FFFF;
            r32 = a[31:0];
         end else if (!f[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) begin
            q32 = a[31:0];
            r32 = 32'h0;
         end else if (!f[0]) begin
            q32 = s1 / s2;
            r32 = s1 % s2;
         end else begin
            q32 = a[31:0] / b[31:0];
            r32 = a[31:0] % b[31:0];
         end
         return sx32(f[1] ? r32 : q32);
      end
      sa = a;
      sb = b;
      if (b == 64'h0) begin
         q = '1;
         r = a;
      end else if (!f[0] && a == 64'h8000_0000_0000_0000 && b == '1) begin
         q = a;
         r = 64'h0;
      end else if (!f[0]) begin
         q = sa / sb;
         r = sa % sb;
      end else begin
         q = a / b;
         r = a % b;
      end
      return f[1] ? r : q;
   endfunction

   function automatic int ref_latency(input logic [2:0] f, input logic w,
                                      input logic [63:0] a, input logic [63:0] b);
      if (!f[2]) return w ? 34 : 66;
      if (w) begin
         if (b[31:0] == 32'h0) return 1;
         if (!f[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) return 1;
         return 34;
      end
      if (b == 64'h0) return 1;
      if (!f[0] && a == 64'h8000_0000_0000_0000 && b == '1) return 1;
      return 66;
   endfunction

   function automatic logic [63:0] pick();
      case ($urandom_range(0, 8))
         0:       return 64'h0;
         1:       return '1;
         2:       return 64'h8000_0000_0000_0000;
         3:       return 64'($urandom_range(0, 9));
         4:       return -64'($urandom_range(1, 9));
         5:       return {32'($urandom), 32'h8000_0000};
         6:       return {32'($urandom), 32'hFFFF_FFFF};
         default: return {32'($urandom), 32'($urandom)};
      endcase
   endfunction

   // Waits for idle, presents one request and returns #1 after the accept edge.
   task automatic issue(input logic [2:0] f, input logic w, input logic [63:0] a,
                        input logic [63:0] b);
      int guard = 0;
      while (!in_ready && guard < 300) begin
         @(posedge clk);
         #1;
         guard++;
      end
      if (guard >= 300) check("issue_wait_idle", 64'(in_ready), 64'd1);
      @(negedge clk);
      in_valid = 1'b1;
      func3    = f;
      word     = w;
      rs1      = a;
      rs2      = b;
      @(posedge clk);
      #1;
      // Later operand changes must not affect the result.
      in_valid = 1'b0;
      func3    = 3'($urandom);
      word     = 1'($urandom);
      rs1      = {32'($urandom), 32'($urandom)};
      rs2      = {32'($urandom), 32'($urandom)};
   endtask

   task automatic finish_op(input string tag, input logic [63:0] exp, input int exp_lat,
                            input int hold);
      int lat   = 1;
      int early = 0;
      while (!out_valid && lat < 300) begin
         if (in_ready) early++;
         @(posedge clk);
         #1;
         lat++;
      end
      check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      check({tag, "_rd"}, rd, exp);
      check({tag, "_busy"}, 64'(early), 64'd0);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         check({tag, "_hold_rd"}, rd, exp);
         check({tag, "_hold_flags"}, 64'({out_valid, in_ready}), 64'd2);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({tag, "_release"}, 64'({out_valid, in_ready}), 64'd1);
   endtask

   task automatic directed(input string tag, input logic [2:0] f, input logic w,
                           input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] exp, input int exp_lat, input int hold);
      issue(f, w, a, b);
      finish_op(tag, exp, exp_lat, hold);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen;
      logic [2:0]  f;
      logic        w;
      logic [63:0] a, b;

      // Reset: requests ignored while rst is high
      rst       = 1'b1;
      in_valid  = 1'b1;
      func3     = 3'b100;
      word      = 1'b0;
      rs1       = 64'd5;
      rs2       = 64'd0;
      kill      = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_rd", rd, 64'd0);
      @(negedge clk);
      in_valid = 1'b0;
      rst      = 1'b0;
      @(posedge clk);
      #1;
      check("post_rst_flags", 64'({out_valid, in_ready}), 64'd1);

      // Directed values (the MUL case also holds DONE for 10 cycles)
      directed("mul", 3'b000, 1'b0, 64'hF, 64'hFFFF_FFFF_FFFF_FFFD,
               64'hFFFF_FFFF_FFFF_FFD3, 66, 10);
      directed("mulh", 3'b001, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
               64'h4000_0000_0000_0000, 66, 0);
      directed("mulhu", 3'b011, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 66, 0);
      directed("mulhsu", 3'b010, 1'b0, '1, 64'd2, '1, 66, 0);
      directed("div", 3'b100, 1'b0, -64'd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66, 0);
      directed("rem", 3'b110, 1'b0, -64'd7, 64'd2, '1, 66, 0);
      directed("divu", 3'b101, 1'b0, '1, 64'd2, 64'h7FFF_FFFF_FFFF_FFFF, 66, 0);
      directed("div_by0", 3'b100, 1'b0, 64'd5, 64'd0, '1, 1, 0);
      directed("rem_by0", 3'b110, 1'b0, 64'd5, 64'd0, 64'd5, 1, 0);
      directed("div_ovf", 3'b100, 1'b0, 64'h8000_0000_0000_0000, '1,
               64'h8000_0000_0000_0000, 1, 0);
      directed("rem_ovf", 3'b110, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 1, 0);
      directed("mulw", 3'b000, 1'b1, 64'h1234_5678_7FFF_FFFF, 64'd2,
               64'hFFFF_FFFF_FFFF_FFFE, 34, 0);
      directed("mulhw_as_mulw", 3'b001, 1'b1, 64'h1234_5678_7FFF_FFFF, 64'd2,
               64'hFFFF_FFFF_FFFF_FFFE, 34, 0);
      directed("divw_ovf", 3'b100, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF,
               64'hFFFF_FFFF_8000_0000, 1, 0);
      directed("remuw_by0", 3'b111, 1'b1, 64'd7, 64'd0, 64'd7, 1, 0);

      // kill in IDLE blocks acceptance (a special op would otherwise finish at once)
      @(negedge clk);
      in_valid = 1'b1;
      kill     = 1'b1;
      func3    = 3'b100;
      word     = 1'b0;
      rs1      = 64'd9;
      rs2      = 64'd0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      kill     = 1'b0;
      check("kill_idle_flags", 64'({out_valid, in_ready}), 64'd1);

      // kill during CALC
      issue(3'b100, 1'b0, 64'd1_000_000, 64'd7);
      repeat (19) @(posedge clk);
      #1;
      check("kill_calc_busy", 64'(in_ready), 64'd0);
      @(negedge clk);
      kill = 1'b1;
      @(posedge clk);
      #1;
      kill = 1'b0;
      check("kill_calc_flags", 64'({out_valid, in_ready}), 64'd1);
      seen = 0;
      for (int i = 0; i < 70; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) seen++;
      end
      check("kill_no_result", 64'(seen), 64'd0);
      directed("after_kill", 3'b101, 1'b0, 64'd100, 64'd7, 64'd14, 66, 0);

      // kill together with out_ready in DONE
      issue(3'b110, 1'b0, 64'd11, 64'd0);
      check("kill_done_valid", 64'(out_valid), 64'd1);
      @(negedge clk);
      kill      = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      kill      = 1'b0;
      out_ready = 1'b0;
      check("kill_done_flags", 64'({out_valid, in_ready}), 64'd1);

      // rst pulse mid-CALC: outputs return to reset values immediately
      issue(3'b000, 1'b0, 64'd3, 64'd5);
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_flags", 64'({out_valid, in_ready}), 64'd1);
      check("midrst_rd", rd, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 70; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) seen++;
      end
      check("midrst_no_result", 64'(seen), 64'd0);

      // Randomized operations against the reference model
      for (int n = 0; n < 120; n++) begin
         f = 3'($urandom);
         w = ($urandom_range(0, 2) == 0);
         a = pick();
         b = pick();
         issue(f, w, a, b);
         finish_op($sformatf("rnd%0d_f%0d_w%0d", n, f, w), ref_model(f, w, a, b),
                   ref_latency(f, w, a, b), $urandom_range(0, 2));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
